// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: streams two WIDTH-bit operands LSB first
// through a single 1-bit add/sub cell and produces the result with N/Z/C/V flags.

module serial_addsub_cell (
  input  logic a,
  input  logic b,
  input  logic sub,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic b_eff;

  // Subtraction is a + ~b + 1; the +1 arrives as the initial carry.
  assign b_eff = b ^ sub;
  assign s     = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

endmodule

// Handshake: start is a request sampled on any rising edge where the block is
// not busy (IDLE or DONE); done is a one-cycle strobe marking result/flags valid.
module serial_addsub_ctrl #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             sub_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;

  logic             cell_s;
  logic             cell_cout;
  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] result_next;

  serial_addsub_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .sub  (sub_q),
    .cin  (carry_q),
    .s    (cell_s),
    .cout (cell_cout)
  );

  assign last_bit    = (cnt == CNT_W'(WIDTH - 1));
  assign accept      = start && (state != ST_RUN);
  assign result_next = {cell_s, result[WIDTH-1:1]};

  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (accept) begin
        state     <= ST_RUN;
        a_sr      <= a;
        b_sr      <= b;
        sub_q     <= sub;
        carry_q   <= sub;
        cnt       <= '0;
        result    <= '0;
        negative  <= 1'b0;
        zero      <= 1'b0;
        carry_out <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        case (state)
          ST_RUN: begin
            result  <= result_next;
            a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
            carry_q <= cell_cout;
            cnt     <= cnt + CNT_W'(1);
            if (last_bit) begin
              // carry_q still holds the carry into the MSB cell here.
              state     <= ST_DONE;
              negative  <= cell_s;
              zero      <= (result_next == '0);
              carry_out <= cell_cout;
              overflow  <= carry_q ^ cell_cout;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
